// File: rtl/dtw_pkg.sv
// -----------------------------------------------------------------------------
// dtw_pkg
// Shared types, constants and arithmetic helpers for the DTW cost-matrix
// sequencer. All cost values are DATA_W-bit unsigned; the all-ones value is
// treated as infinity by both the saturating add and the three-way min.
// -----------------------------------------------------------------------------
package dtw_pkg;

    localparam int DATA_W = 32;
    localparam logic [DATA_W-1:0] COST_INF = '1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        UPDATE = 3'd3,
        DONE   = 3'd4
    } state_e;

    // Unsigned add that clamps to COST_INF instead of wrapping.
    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DATA_W] ? COST_INF : sum[DATA_W-1:0];
    endfunction

    // COST_INF is the largest unsigned value, so a plain unsigned min
    // already treats it as infinity.
    function automatic logic [DATA_W-1:0] min3(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] c);
        logic [DATA_W-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage

// File: rtl/dtw_row_buf.sv
// -----------------------------------------------------------------------------
// dtw_row_buf
// One-row cost buffer: DEPTH x WIDTH register array with a synchronous write
// and a combinational read at the same address.
// Ports:
//   clk    clock
//   we     write enable
//   addr   read/write address (column index)
//   wdata  write data
//   rdata  combinational read data at addr (value before this cycle's write)
// -----------------------------------------------------------------------------
module dtw_row_buf #(
    parameter int DEPTH  = 64,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the storage array has no reset; every entry is written in row 0
    // before it is ever read, so reset would only cost logic.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/dtw_matrix_ctrl.sv
// -----------------------------------------------------------------------------
// dtw_matrix_ctrl
// Sequencer for the DTW cost matrix. Walks the len_a x len_b grid row-major,
// issues one cell request at a time to the distance datapath and accumulates
// D(i,j) = dist + min(up, left, diag) with a one-row buffer. The final
// D(len_a-1, len_b-1) is reported on result with a one-cycle done pulse.
// Ports:
//   ACLK, ARESET          clock, synchronous active-high reset
//   start, len_a, len_b   start strobe and grid size (1..MAX_LEN each)
//   cell_req_*            request (cell_i, cell_j) to the datapath, valid/ready
//   cell_rsp_valid/dist   local distance for the outstanding cell
//   busy, done            run in progress / completion pulse
//   result, err           final cost / illegal-length flag, held until next run
// Optional feature: define DTW_BAND_EN to enable a Sakoe-Chiba band of width
// BAND; out-of-band cells are not requested and cost COST_INF.
// -----------------------------------------------------------------------------
module dtw_matrix_ctrl
    import dtw_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int DATA_W  = dtw_pkg::DATA_W,   // must match the package width
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
`ifdef DTW_BAND_EN
    ,
    parameter int BAND    = 8
`endif
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              start,
    input  logic [LEN_W-1:0]  len_a,
    input  logic [LEN_W-1:0]  len_b,
    output logic              cell_req_valid,
    input  logic              cell_req_ready,
    output logic [LEN_W-1:0]  cell_i,
    output logic [LEN_W-1:0]  cell_j,
    input  logic              cell_rsp_valid,
    input  logic [DATA_W-1:0] cell_dist,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              err
);

    localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    state_e            state_q, state_d;
    logic              pending_q, pending_d;
    logic [LEN_W-1:0]  len_a_q, len_a_d, len_b_q, len_b_d;
    logic [LEN_W-1:0]  i_q, i_d, j_q, j_d;
    logic [DATA_W-1:0] dist_q, dist_d, left_q, left_d, diag_q, diag_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              err_q, err_d, done_q, done_d, busy_q, busy_d;
    logic              req_valid_q, req_valid_d;

    logic [DATA_W-1:0] up;
    logic [DATA_W-1:0] cost;
    logic              row_end, last_cell, illegal;
    logic [LEN_W-1:0]  i_nxt, j_nxt;
    logic              skip_nxt, skip_cur;

`ifdef DTW_BAND_EN
    localparam logic [LEN_W-1:0] BAND_L = LEN_W'(BAND);

    function automatic logic outside_band(input logic [LEN_W-1:0] a,
                                          input logic [LEN_W-1:0] b);
        logic [LEN_W-1:0] diff;
        diff = (a > b) ? (a - b) : (b - a);
        return diff > BAND_L;
    endfunction
`endif

    dtw_row_buf #(
        .DEPTH  (MAX_LEN),
        .WIDTH  (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_row_buf (
        .clk   (ACLK),
        .we    (state_q == UPDATE),
        .addr  (j_q[ADDR_W-1:0]),
        .wdata (cost),
        .rdata (up)
    );

    // Next-cell indices and cost of the current cell. row_buf[j] still holds
    // the previous row's value here, which is both "up" for this cell and
    // "diag" for the next one.
    always_comb begin
        row_end   = (j_q == len_b_q - 1'b1);
        last_cell = row_end && (i_q == len_a_q - 1'b1);
        j_nxt     = row_end ? '0 : j_q + 1'b1;
        i_nxt     = row_end ? i_q + 1'b1 : i_q;
        illegal   = (len_a_q == '0) || (len_a_q > MAX_LEN_L) ||
                    (len_b_q == '0) || (len_b_q > MAX_LEN_L);
`ifdef DTW_BAND_EN
        illegal   = illegal || outside_band(len_a_q, len_b_q);
        skip_cur  = outside_band(i_q, j_q);
        skip_nxt  = outside_band(i_nxt, j_nxt);
`else
        skip_cur  = 1'b0;
        skip_nxt  = 1'b0;
`endif
        if (i_q == '0 && j_q == '0) begin
            cost = dist_q;
        end else if (i_q == '0) begin
            cost = sat_add(dist_q, left_q);
        end else if (j_q == '0) begin
            cost = sat_add(dist_q, up);
        end else begin
            cost = sat_add(dist_q, min3(up, left_q, diag_q));
        end
        if (skip_cur) begin
            cost = COST_INF;
        end
    end

    // NOTE: every signal assigned below gets its hold value first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        len_a_d     = len_a_q;
        len_b_d     = len_b_q;
        i_d         = i_q;
        j_d         = j_q;
        dist_d      = dist_q;
        left_d      = left_q;
        diag_d      = diag_q;
        result_d    = result_q;
        err_d       = err_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        req_valid_d = req_valid_q;

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    // Lengths were latched with start last cycle; decide now.
                    pending_d = 1'b0;
                    result_d  = '0;
                    if (illegal) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        err_d       = 1'b0;
                        i_d         = '0;
                        j_d         = '0;
                        req_valid_d = 1'b1;
                        state_d     = ISSUE;
                    end
                end else if (start) begin
                    pending_d = 1'b1;
                    len_a_d   = len_a;
                    len_b_d   = len_b;
                    busy_d    = 1'b1;
                end
            end
            ISSUE: begin
                if (cell_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (cell_rsp_valid) begin
                    dist_d  = cell_dist;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                diag_d = up;
                left_d = cost;
                i_d    = i_nxt;
                j_d    = j_nxt;
                if (last_cell) begin
                    result_d = cost;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = DONE;
                end else if (skip_nxt) begin
                    state_d = UPDATE;
                end else begin
                    req_valid_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its _d input regardless of ordering.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            len_a_q     <= '0;
            len_b_q     <= '0;
            i_q         <= '0;
            j_q         <= '0;
            dist_q      <= '0;
            left_q      <= '0;
            diag_q      <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            req_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            len_a_q     <= len_a_d;
            len_b_q     <= len_b_d;
            i_q         <= i_d;
            j_q         <= j_d;
            dist_q      <= dist_d;
            left_q      <= left_d;
            diag_q      <= diag_d;
            result_q    <= result_d;
            err_q       <= err_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            req_valid_q <= req_valid_d;
        end
    end

    assign cell_req_valid = req_valid_q;
    assign cell_i         = i_q;
    assign cell_j         = j_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign result         = result_q;
    assign err            = err_q;

endmodule

// File: tb/tb_dtw_matrix_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dtw_matrix_ctrl
// Self-checking bench for dtw_matrix_ctrl. A bench-side datapath model answers
// cell requests; expected request order and final cost come from a full-matrix
// DTW reference and are queued when a run is started, then popped as the DUT
// produces requests and results.
// -----------------------------------------------------------------------------
module tb_dtw_matrix_ctrl;

    localparam int MAX_LEN = 64;
    localparam int DATA_W  = 32;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    typedef struct {
        int i;
        int j;
    } req_t;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  len_a = '0;
    logic [LEN_W-1:0]  len_b = '0;
    logic              cell_req_valid;
    logic              cell_req_ready = 1'b0;
    logic [LEN_W-1:0]  cell_i;
    logic [LEN_W-1:0]  cell_j;
    logic              cell_rsp_valid = 1'b0;
    logic [DATA_W-1:0] cell_dist = '0;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              err;

    int vec_cnt = 0;
    int err_cnt = 0;

    req_t              req_q[$];
    logic [DATA_W-1:0] res_q[$];

    always #5 ACLK = ~ACLK;

    dtw_matrix_ctrl u_dut (
        .ACLK           (ACLK),
        .ARESET         (ARESET),
        .start          (start),
        .len_a          (len_a),
        .len_b          (len_b),
        .cell_req_valid (cell_req_valid),
        .cell_req_ready (cell_req_ready),
        .cell_i         (cell_i),
        .cell_j         (cell_j),
        .cell_rsp_valid (cell_rsp_valid),
        .cell_dist      (cell_dist),
        .busy           (busy),
        .done           (done),
        .result         (result),
        .err            (err)
    );

    function automatic logic [DATA_W-1:0] dist_of(input int i, input int j,
                                                  input logic [DATA_W-1:0] cval,
                                                  input bit absd);
        if (absd) return DATA_W'((i > j) ? (i - j) : (j - i));
        return cval;
    endfunction

    // Textbook DTW over the full matrix with saturation at all-ones.
    function automatic logic [DATA_W-1:0] ref_dtw(input int la, input int lb,
                                                  input logic [DATA_W-1:0] cval,
                                                  input bit absd);
        logic [DATA_W-1:0] d [MAX_LEN][MAX_LEN];
        logic [DATA_W-1:0] m, dv;
        logic [DATA_W:0]   s;
        for (int i = 0; i < la; i++) begin
            for (int j = 0; j < lb; j++) begin
                dv = dist_of(i, j, cval, absd);
                if (i == 0 && j == 0) begin
                    d[i][j] = dv;
                end else begin
                    m = '1;
                    if (i > 0 && d[i-1][j] < m) m = d[i-1][j];
                    if (j > 0 && d[i][j-1] < m) m = d[i][j-1];
                    if (i > 0 && j > 0 && d[i-1][j-1] < m) m = d[i-1][j-1];
                    s = {1'b0, dv} + {1'b0, m};
                    d[i][j] = s[DATA_W] ? '1 : s[DATA_W-1:0];
                end
            end
        end
        return d[la-1][lb-1];
    endfunction

    // Drives one run and checks it. stall: cycles ready is held low on the
    // first request. inject_at: cycle at which a stray start is pulsed.
    // abort_at: after this many accepted requests, reset during WAIT.
    task automatic run_job(input string tag, input int la, input int lb,
                           input logic [DATA_W-1:0] cval, input bit absd,
                           input int stall, input int inject_at, input int abort_at);
        bit                legal;
        int                k, busy_cnt, accepted, stall_left, budget, exp_lat;
        bit                got_done, rsp_pend, holding;
        logic [DATA_W-1:0] rsp_dist, exp_res;
        logic [LEN_W-1:0]  held_i, held_j;
        req_t              r;

        legal = (la >= 1) && (la <= MAX_LEN) && (lb >= 1) && (lb <= MAX_LEN);
        req_q.delete();
        res_q.delete();
        if (legal) begin
            for (int i = 0; i < la; i++)
                for (int j = 0; j < lb; j++) begin
                    r.i = i;
                    r.j = j;
                    req_q.push_back(r);
                end
            res_q.push_back(ref_dtw(la, lb, cval, absd));
        end else begin
            res_q.push_back('0);
        end
        exp_lat = legal ? (3 * la * lb + 2 + stall) : 2;
        budget  = exp_lat + 40;

        start = 1'b1;
        len_a = LEN_W'(la);
        len_b = LEN_W'(lb);
        @(posedge ACLK); #1;
        start = 1'b0;

        k = 1; busy_cnt = 0; accepted = 0; got_done = 0; rsp_pend = 0;
        holding = 0; stall_left = 0; rsp_dist = '0; held_i = '0; held_j = '0;
        while (k <= budget) begin
            cell_req_ready = 1'b0;
            cell_rsp_valid = 1'b0;
            start          = 1'b0;
            if (rsp_pend && abort_at != 0 && accepted == abort_at) begin
                vec_cnt++;
                if (busy !== 1'b1) begin
                    err_cnt++;
                    $display("FAIL %s busy_before_abort: got %b want 1", tag, busy);
                end
                ARESET = 1'b1;
                @(posedge ACLK); #1;
                ARESET = 1'b0;
                vec_cnt++;
                if ({cell_req_valid, busy, done, err, result, cell_i, cell_j} !== '0) begin
                    err_cnt++;
                    $display("FAIL %s outputs_after_reset: got v=%b b=%b d=%b e=%b r=%0h i=%0d j=%0d want all 0",
                             tag, cell_req_valid, busy, done, err, result, cell_i, cell_j);
                end
                // A response arriving after the abort must be ignored.
                cell_rsp_valid = 1'b1;
                cell_dist      = 32'd5;
                @(posedge ACLK); #1;
                cell_rsp_valid = 1'b0;
                for (int c = 0; c < 6; c++) begin
                    vec_cnt++;
                    if ({cell_req_valid, busy, done} !== 3'b000) begin
                        err_cnt++;
                        $display("FAIL %s quiet_after_reset: cycle %0d got v=%b b=%b d=%b want 000",
                                 tag, c, cell_req_valid, busy, done);
                    end
                    @(posedge ACLK); #1;
                end
                req_q.delete();
                res_q.delete();
                return;
            end
            if (rsp_pend) begin
                cell_rsp_valid = 1'b1;
                cell_dist      = rsp_dist;
                rsp_pend       = 0;
            end
            if (k == inject_at) begin
                start = 1'b1;
                len_a = LEN_W'(1);
                len_b = LEN_W'(1);
            end
            if (done === 1'b1) begin
                got_done = 1;
                break;
            end
            if (busy === 1'b1) busy_cnt++;
            if (holding && cell_req_valid !== 1'b1) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL %s valid_withdrawn: got %b want 1", tag, cell_req_valid);
                holding = 0;
            end
            if (cell_req_valid === 1'b1) begin
                if (!holding) begin
                    holding    = 1;
                    held_i     = cell_i;
                    held_j     = cell_j;
                    stall_left = (accepted == 0) ? stall : 0;
                end else begin
                    vec_cnt++;
                    if (cell_i !== held_i || cell_j !== held_j) begin
                        err_cnt++;
                        $display("FAIL %s req_stable: got (%0d,%0d) want (%0d,%0d)",
                                 tag, cell_i, cell_j, held_i, held_j);
                    end
                end
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    cell_req_ready = 1'b1;
                    holding        = 0;
                    vec_cnt++;
                    if (req_q.size() == 0) begin
                        err_cnt++;
                        $display("FAIL %s unexpected_req: got (%0d,%0d) want none", tag, cell_i, cell_j);
                    end else begin
                        r = req_q.pop_front();
                        if (int'(cell_i) != r.i || int'(cell_j) != r.j) begin
                            err_cnt++;
                            $display("FAIL %s req_order: got (%0d,%0d) want (%0d,%0d)",
                                     tag, cell_i, cell_j, r.i, r.j);
                        end
                    end
                    rsp_pend = 1;
                    rsp_dist = dist_of(int'(cell_i), int'(cell_j), cval, absd);
                    accepted++;
                end
            end
            @(posedge ACLK); #1;
            k++;
        end
        cell_req_ready = 1'b0;
        cell_rsp_valid = 1'b0;
        start          = 1'b0;

        vec_cnt++;
        if (!got_done) begin
            err_cnt++;
            $display("FAIL %s done_timeout: no done within %0d cycles", tag, budget);
            return;
        end
        vec_cnt++;
        if (k != exp_lat) begin
            err_cnt++;
            $display("FAIL %s done_latency: got %0d want %0d", tag, k, exp_lat);
        end
        vec_cnt++;
        if (busy_cnt != exp_lat - 1) begin
            err_cnt++;
            $display("FAIL %s busy_cycles: got %0d want %0d", tag, busy_cnt, exp_lat - 1);
        end
        exp_res = res_q.pop_front();
        vec_cnt++;
        if (result !== exp_res) begin
            err_cnt++;
            $display("FAIL %s result: got %0h want %0h", tag, result, exp_res);
        end
        vec_cnt++;
        if (err !== !legal) begin
            err_cnt++;
            $display("FAIL %s err: got %b want %b", tag, err, !legal);
        end
        vec_cnt++;
        if (req_q.size() != 0) begin
            err_cnt++;
            $display("FAIL %s missing_reqs: got %0d left want 0", tag, req_q.size());
        end
        @(posedge ACLK); #1;
        vec_cnt++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== exp_res) begin
            err_cnt++;
            $display("FAIL %s after_done: got d=%b b=%b r=%0h want d=0 b=0 r=%0h",
                     tag, done, busy, result, exp_res);
        end
        @(posedge ACLK); #1;
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        vec_cnt++;
        if ({cell_req_valid, busy, done, err, result, cell_i, cell_j} !== '0) begin
            err_cnt++;
            $display("FAIL reset_state: got v=%b b=%b d=%b e=%b r=%0h i=%0d j=%0d want all 0",
                     cell_req_valid, busy, done, err, result, cell_i, cell_j);
        end
        ARESET = 1'b0;
        @(posedge ACLK); #1;
        vec_cnt++;
        if ({cell_req_valid, busy, done} !== 3'b000) begin
            err_cnt++;
            $display("FAIL idle_after_reset: got v=%b b=%b d=%b want 000", cell_req_valid, busy, done);
        end
    endtask

    task automatic test_single();
        run_job("1x1", 1, 1, 32'd7, 1'b0, 0, 0, 0);
    endtask

    task automatic test_order();
        run_job("2x2", 2, 2, 32'd1, 1'b0, 0, 0, 0);
    endtask

    task automatic test_abs_dist();
        run_job("3x3_abs", 3, 3, 32'd0, 1'b1, 0, 0, 0);
        run_job("3x2_abs", 3, 2, 32'd0, 1'b1, 0, 0, 0);
        run_job("5x7_abs", 5, 7, 32'd0, 1'b1, 0, 0, 0);
    endtask

    task automatic test_saturate();
        run_job("2x1_sat", 2, 1, 32'hFFFF_FFF0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_illegal();
        run_job("len_a_0", 0, 4, 32'd1, 1'b0, 0, 0, 0);
        run_job("len_b_65", 4, 65, 32'd1, 1'b0, 0, 0, 0);
    endtask

    task automatic test_stall_and_busy_start();
        run_job("stall_2x2", 2, 2, 32'd3, 1'b0, 10, 3, 0);
    endtask

    task automatic test_abort();
        run_job("abort_4x4", 4, 4, 32'd1, 1'b0, 0, 0, 3);
        run_job("post_abort_1x1", 1, 1, 32'd7, 1'b0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_job("max_1x64", 1, 64, 32'd2, 1'b0, 0, 0, 0);
        run_job("b2b_4x3", 4, 3, 32'd0, 1'b1, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_order();
        test_abs_dist();
        test_saturate();
        test_illegal();
        test_stall_and_busy_start();
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
